transaction_control: RTL and testbench
======================================

// Module: transaction_control
// PURPOSE
//  Responder side of the main controller's transaction handshake.
//  Starts when start_transaction rises. Reads the sender key and both player balances from the shared balance memory.
//  Validates the key and the amount, writes the updated balances back, and launches the result animation.
//  Holds finished_transaction high until start_transaction drops.
// PARAMETERS
//  DATA_W        8    width of balances, keys, amount
//  ADDR_W        2    memory address width; map: 0=P1 bal, 1=P2 bal, 2=P1 key, 3=P2 key
//  ANIM_TIMEOUT  1023 max cycles to wait for anim_done before proceeding (>=1)
// PORTS
//  clock              in   1       system clock, all logic rising-edge
//  reset              in   1       synchronous, active-high
//  start_transaction  in   1       level request from main control; held high for the whole transaction
//  sender             in   1       0: P1 pays P2, 1: P2 pays P1; sampled in IDLE
//  amount             in   DATA_W  transfer amount; sampled in IDLE
//  key                in   DATA_W  key entered by sender; sampled in IDLE
//  mem_rdata          in   DATA_W  memory read data, valid 1 cycle after mem_addr
//  anim_done          in   1       animation block finished (level or pulse)
//  mem_addr           out  ADDR_W  memory address
//  mem_wdata          out  DATA_W  memory write data
//  mem_we             out  1       memory write enable, one cycle per write
//  anim_start         out  1       one-cycle pulse launching the animation
//  status             out  2       00 ok, 01 bad key, 10 insufficient funds, 11 receiver overflow
//  finished_transaction out 1      done indication back to main control
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; status=00; captured regs=0. Reset mid-transaction aborts at the next edge.
//   A reset between WR_S and WR_R leaves a partial write; main control re-initialises memory.
//  Outputs are Moore-decoded from state and captured registers. No output depends combinationally on inputs.
//  Sequence: IDLE -> RD_KEY -> RD_SBAL -> RD_RBAL -> CHECK -> [WR_S -> WR_R] -> ANIM -> DONE -> IDLE.
//   IDLE: on start_transaction=1, latch sender/amount/key; go to RD_KEY.
//   RD_KEY: mem_addr = 2+sender.
//   RD_SBAL: mem_addr = sender; capture mem_rdata as stored_key.
//   RD_RBAL: mem_addr = !sender; capture sender balance s_bal.
//   CHECK: capture receiver balance r_bal. Set status by priority:
//    key!=stored_key -> 01; else amount>s_bal -> 10; else r_bal+amount > 2^DATA_W-1 (DATA_W+1-bit sum) -> 11; else 00.
//    status=00 goes to WR_S; any other status goes to ANIM.
//   WR_S: mem_we=1, mem_addr=sender, mem_wdata=s_bal-amount.
//   WR_R: mem_we=1, mem_addr=!sender, mem_wdata=r_bal+amount.
//   ANIM: anim_start=1 in first ANIM cycle only; timeout counter cleared on entry.
//    Leave on anim_done=1 or counter==ANIM_TIMEOUT-1.
//   DONE: finished_transaction=1; stay while start_transaction=1; go to IDLE when it is 0.
//  Latency: start seen at edge E -> finished_transaction high at E+7 (ok path) or E+5 (reject path),
//   assuming anim_done is high in the first ANIM cycle.
//  status holds its value from CHECK until the next transaction reaches CHECK.
//  amount=0 with a valid key is accepted; both balances are rewritten unchanged.
//  start_transaction dropping before DONE is ignored; the transaction completes, and DONE exits immediately.
//  anim_done asserted outside ANIM is ignored. mem_we is never high outside WR_S/WR_R.
// TESTING
//  1. P1 bal=50, P2 bal=10, P1 key=0x5A; sender=0, key=0x5A, amount=20 -> writes addr0=30 then addr1=30;
//     status=00; finished_transaction at start+7.
//  2. Same setup with key=0x5B -> status=01, mem_we never asserted, anim_start pulses once, finished at start+5.
//  3. sender=1, P2 bal=10, key ok, amount=11 -> status=10, no writes; amount=10 -> P2=0, P1=+10, status=00.
//  4. P2 bal=250, sender=0, amount=6 -> status=11, no writes; amount=5 -> P2=255.
//  5. anim_done held 0 with ANIM_TIMEOUT=4 -> exits ANIM after 4 cycles. Hold start_transaction 3 extra cycles
//     -> finished_transaction stays 1, then IDLE one cycle after start drops.
//  6. Assert reset in WR_S -> next cycle IDLE, all outputs 0. A new start with a bad key runs a normal reject.

Source files
------------

// File: rtl/transaction_control.sv
// Responder side of the main controller's transaction handshake.
// Reads the sender key and both balances from the shared balance memory,
// validates key and amount, writes the new balances back, launches the
// result animation and holds finished_transaction until start drops.
module transaction_control #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int ANIM_TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_transaction,
    input  logic              sender,
    input  logic [DATA_W-1:0] amount,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              anim_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              anim_start,
    output logic [1:0]        status,
    output logic              finished_transaction
);

    localparam int CNT_W = (ANIM_TIMEOUT > 1) ? $clog2(ANIM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TIMEOUT - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_KEY  = 4'd1;
    localparam logic [3:0] S_RD_SBAL = 4'd2;
    localparam logic [3:0] S_RD_RBAL = 4'd3;
    localparam logic [3:0] S_CHECK   = 4'd4;
    localparam logic [3:0] S_WR_S    = 4'd5;
    localparam logic [3:0] S_WR_R    = 4'd6;
    localparam logic [3:0] S_ANIM    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic              sender_q;
    logic [DATA_W-1:0] amount_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] stored_key;
    logic [DATA_W-1:0] s_bal;
    logic [DATA_W-1:0] r_bal;
    logic [1:0]        status_q;
    logic [1:0]        status_chk;
    logic [CNT_W-1:0]  anim_cnt;

    // Validation priority: bad key, then insufficient funds, then receiver
    // overflow (detected on the carry of a DATA_W+1 bit sum).
    function automatic logic [1:0] check_status(
        input logic [DATA_W-1:0] k,
        input logic [DATA_W-1:0] sk,
        input logic [DATA_W-1:0] amt,
        input logic [DATA_W-1:0] sb,
        input logic [DATA_W-1:0] rb
    );
        logic [DATA_W:0] sum;
        logic [1:0]      res;
        sum = {1'b0, rb} + {1'b0, amt};
        if (k != sk)
            res = 2'b01;
        else if (amt > sb)
            res = 2'b10;
        else if (sum[DATA_W])
            res = 2'b11;
        else
            res = 2'b00;
        return res;
    endfunction

    // In CHECK the receiver balance is still on mem_rdata, so it feeds the check directly.
    assign status_chk = check_status(key_q, stored_key, amount_q, s_bal, mem_rdata);
    assign status     = status_q;

    // Next-state sequencing of the handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_transaction) state_nxt = S_RD_KEY;
            S_RD_KEY:  state_nxt = S_RD_SBAL;
            S_RD_SBAL: state_nxt = S_RD_RBAL;
            S_RD_RBAL: state_nxt = S_CHECK;
            S_CHECK:   state_nxt = (status_chk == 2'b00) ? S_WR_S : S_ANIM;
            S_WR_S:    state_nxt = S_WR_R;
            S_WR_R:    state_nxt = S_ANIM;
            S_ANIM:    if (anim_done || (anim_cnt == CNT_LAST)) state_nxt = S_DONE;
            S_DONE:    if (!start_transaction) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register and animation timeout counter (zero whenever outside ANIM).
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            anim_cnt <= '0;
        end else begin
            state    <= state_nxt;
            anim_cnt <= (state == S_ANIM) ? anim_cnt + 1'b1 : '0;
        end
    end

    // Capture request fields in IDLE and memory read data as it arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            sender_q   <= 1'b0;
            amount_q   <= '0;
            key_q      <= '0;
            stored_key <= '0;
            s_bal      <= '0;
            r_bal      <= '0;
            status_q   <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_transaction) begin
                        sender_q <= sender;
                        amount_q <= amount;
                        key_q    <= key;
                    end
                end
                S_RD_SBAL: stored_key <= mem_rdata;
                S_RD_RBAL: s_bal      <= mem_rdata;
                S_CHECK: begin
                    r_bal    <= mem_rdata;
                    status_q <= status_chk;
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from state and captured registers.
    always_comb begin
        mem_addr             = '0;
        mem_wdata            = '0;
        mem_we               = 1'b0;
        anim_start           = 1'b0;
        finished_transaction = 1'b0;
        case (state)
            S_RD_KEY:  mem_addr = ADDR_W'(2) + ADDR_W'(sender_q);
            S_RD_SBAL: mem_addr = ADDR_W'(sender_q);
            S_RD_RBAL: mem_addr = ADDR_W'(!sender_q);
            S_WR_S: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(sender_q);
                mem_wdata = s_bal - amount_q;
            end
            S_WR_R: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(!sender_q);
                mem_wdata = r_bal + amount_q;
            end
            S_ANIM:    anim_start = (anim_cnt == '0);
            S_DONE:    finished_transaction = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_transaction_control.sv
// Scoreboard bench for transaction_control with a behavioural balance model.
module tb_transaction_control;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int TO = 4;

    logic          clock;
    logic          reset;
    logic          start_transaction;
    logic          sender;
    logic [DW-1:0] amount;
    logic [DW-1:0] key;
    logic [DW-1:0] mem_rdata;
    logic          anim_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          anim_start;
    logic [1:0]    status;
    logic          finished_transaction;

    transaction_control #(.DATA_W(DW), .ADDR_W(AW), .ANIM_TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .start_transaction(start_transaction),
        .sender(sender),
        .amount(amount),
        .key(key),
        .mem_rdata(mem_rdata),
        .anim_done(anim_done),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .anim_start(anim_start),
        .status(status),
        .finished_transaction(finished_transaction)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Shared balance memory: registered read, DUT writes take priority over loader.
    logic [DW-1:0] mem [4];
    logic          tb_we;
    logic [1:0]    tb_addr;
    logic [DW-1:0] tb_wdata;
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        int         st;
        int         nw;
        int         a0;
        int         a1;
        int         d0;
        int         d1;
        int         lat;
        int         flen;
    } exp_t;

    exp_t          exp_q[$];
    logic [9:0]    wlog[$];
    logic [DW-1:0] mdl [4];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            anim_cnt = 0;
    int            fin_len = 0;
    int            lat = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Start-edge tracker: marks the edge a transaction is accepted.
    initial begin
        logic start_prev;
        start_prev = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            if (start_transaction && !start_prev && !reset) begin
                t0 = cyc;
                wlog.delete();
                anim_cnt = 0;
                fin_len  = 0;
            end
            start_prev = start_transaction;
        end
    end

    task automatic compare_txn();
        exp_t e;
        chk("sb_entry_present", int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("status", int'(status), e.st);
        chk("latency", lat, e.lat);
        chk("finished_len", fin_len, e.flen);
        chk("anim_pulses", anim_cnt, 1);
        chk("write_count", wlog.size(), e.nw);
        if (e.nw == 2 && wlog.size() == 2) begin
            chk("wr_s_addr", int'(wlog[0][9:8]), e.a0);
            chk("wr_s_data", int'(wlog[0][7:0]), e.d0);
            chk("wr_r_addr", int'(wlog[1][9:8]), e.a1);
            chk("wr_r_data", int'(wlog[1][7:0]), e.d1);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("mem%0d", i), int'(mem[i]), int'(mdl[i]));
    endtask

    // Output monitor: logs writes and pulses, compares when finished falls.
    initial begin
        logic fin_prev;
        fin_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
            if (anim_start) anim_cnt++;
            if (finished_transaction && !fin_prev) lat = cyc - t0;
            if (finished_transaction) fin_len++;
            if (!finished_transaction && fin_prev) compare_txn();
            fin_prev = finished_transaction;
        end
    end

    task automatic load_mem(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] v [4];
        v[0] = b1; v[1] = b2; v[2] = k1; v[3] = k2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tb_we = 1'b1;
            tb_addr = i[1:0];
            tb_wdata = v[i];
            mdl[i] = v[i];
        end
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic wait_fin(input logic v);
        int n;
        n = 0;
        while (finished_transaction !== v) begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL wait_finished: stuck at %0b required %0b", finished_transaction, v);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    task automatic do_txn(input logic s, input logic [7:0] amt, input logic [7:0] k,
                          input logic ad, input int hold, input bit early);
        exp_t e;
        int   si, ri, sb, rb, sk;
        si = int'(s);
        ri = 1 - si;
        sk = int'(mdl[2 + si]);
        sb = int'(mdl[si]);
        rb = int'(mdl[ri]);
        e.nw = 0;
        e.a0 = si;
        e.a1 = ri;
        e.d0 = (sb - int'(amt)) & 255;
        e.d1 = (rb + int'(amt)) & 255;
        if (int'(k) != sk) e.st = 1;
        else if (int'(amt) > sb) e.st = 2;
        else if (rb + int'(amt) > 255) e.st = 3;
        else begin
            e.st = 0;
            e.nw = 2;
            mdl[si] = 8'(e.d0);
            mdl[ri] = 8'(e.d1);
        end
        e.lat  = ((e.st == 0) ? 7 : 5) + (ad ? 0 : TO - 1);
        e.flen = early ? 1 : hold + 1;
        exp_q.push_back(e);
        @(negedge clock);
        sender = s;
        amount = amt;
        key = k;
        anim_done = ad;
        start_transaction = 1'b1;
        // Scramble request inputs once they should have been latched.
        @(negedge clock);
        sender = ~s;
        amount = 8'($urandom);
        key = 8'($urandom);
        if (early) begin
            @(negedge clock);
            start_transaction = 1'b0;
        end
        wait_fin(1'b1);
        if (!early) begin
            repeat (hold) @(negedge clock);
            start_transaction = 1'b0;
        end
        wait_fin(1'b0);
        @(negedge clock);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_anim_start"}, int'(anim_start), 0);
        chk({tag, "_status"}, int'(status), 0);
        chk({tag, "_finished"}, int'(finished_transaction), 0);
    endtask

    task automatic reset_in_wrs();
        load_mem(8'd50, 8'd10, 8'h5A, 8'h11);
        @(negedge clock);
        sender = 1'b0;
        amount = 8'd20;
        key = 8'h5A;
        anim_done = 1'b1;
        start_transaction = 1'b1;
        repeat (5) @(negedge clock);
        chk("wrs_mem_we", int'(mem_we), 1);
        chk("wrs_mem_addr", int'(mem_addr), 0);
        chk("wrs_mem_wdata", int'(mem_wdata), 30);
        reset = 1'b1;
        start_transaction = 1'b0;
        @(negedge clock);
        chk_idle_outputs("abort");
        reset = 1'b0;
        chk("partial_write_p1", int'(mem[0]), 30);
        chk("partial_write_p2", int'(mem[1]), 10);
        load_mem(8'd50, 8'd10, 8'h5A, 8'h11);
        do_txn(1'b0, 8'd20, 8'h5B, 1'b1, 0, 1'b0);
    endtask

    initial begin
        logic       s;
        logic [7:0] amt, k;
        reset = 1'b1;
        start_transaction = 1'b0;
        sender = 1'b0;
        amount = '0;
        key = '0;
        anim_done = 1'b0;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_wdata = '0;
        repeat (3) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b0;

        load_mem(8'd50, 8'd10, 8'h5A, 8'h00);
        do_txn(1'b0, 8'd20, 8'h5A, 1'b1, 0, 1'b0);
        load_mem(8'd50, 8'd10, 8'h5A, 8'h00);
        do_txn(1'b0, 8'd20, 8'h5B, 1'b1, 0, 1'b0);
        load_mem(8'd100, 8'd10, 8'h00, 8'h3C);
        do_txn(1'b1, 8'd11, 8'h3C, 1'b1, 1, 1'b0);
        do_txn(1'b1, 8'd10, 8'h3C, 1'b1, 0, 1'b0);
        load_mem(8'd100, 8'd250, 8'h77, 8'h00);
        do_txn(1'b0, 8'd6, 8'h77, 1'b1, 0, 1'b0);
        do_txn(1'b0, 8'd5, 8'h77, 1'b1, 0, 1'b0);
        do_txn(1'b1, 8'd0, 8'h00, 1'b1, 2, 1'b0);
        do_txn(1'b0, 8'd1, 8'h77, 1'b0, 3, 1'b0);
        do_txn(1'b0, 8'd1, 8'h00, 1'b1, 0, 1'b1);
        reset_in_wrs();

        for (int g = 0; g < 5; g++) begin
            load_mem(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            for (int t = 0; t < 8; t++) begin
                s = 1'($urandom_range(0, 1));
                k = ($urandom_range(0, 3) != 0) ? mdl[2 + int'(s)] : 8'($urandom);
                case ($urandom_range(0, 3))
                    0: amt = 8'($urandom);
                    1: amt = mdl[int'(s)] + 8'($urandom_range(0, 1));
                    2: amt = 8'(8'd255 - mdl[1 - int'(s)]) + 8'($urandom_range(0, 1));
                    default: amt = 8'($urandom_range(0, 5));
                endcase
                do_txn(s, amt, k, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       ($urandom_range(0, 7) == 0));
            end
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
